// File: rtl/ps2_kb_pkg.sv
// Shared types and constants for the PS/2 scancode-set-2 key tracker.
package ps2_kb_pkg;

    // Prefix-decoder state: which prefix bytes have been seen for the current code.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // {extended, scancode}
    typedef logic [8:0] ps2_code_t;

    localparam ps2_code_t KC_ENTER = 9'h05A;
    localparam ps2_code_t KC_LEFT  = 9'h16B;
    localparam ps2_code_t KC_RIGHT = 9'h174;

    function automatic logic state_is_ext(input ps2_state_t s);
        return (s == EXT) || (s == EXT_BRK);
    endfunction

    function automatic logic state_is_brk(input ps2_state_t s);
        return (s == BRK) || (s == EXT_BRK);
    endfunction

endpackage

// File: rtl/ps2_code_match.sv
// Compares one completed {ext,code} against every programmed key slot.
// Duplicate slots all report a match.
module ps2_code_match
    import ps2_kb_pkg::*;
#(
    parameter int                      NUM_KEYS  = 3,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES = {KC_RIGHT, KC_LEFT, KC_ENTER}
) (
    input  ps2_code_t                  code,
    output logic [NUM_KEYS-1:0]        match
);

    // One 9-bit equality comparator per slot; the extended bit takes part.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cmp
        assign match[i] = (KEY_CODES[9*i +: 9] == code);
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 decoder: tracks make/break of NUM_KEYS programmable keys,
// handles E0 / F0 / E0 F0 prefixes and drops stale prefixes after a timeout.
// Optional feature macro: PS2_KEY_REPEAT_EN adds the key_repeat output, which
// pulses on a typematic make of an already-held key.
// Handshake: ps2_key_data is valid only in a cycle where ps2_key_pressed is 1;
// there is no back-pressure, every strobe (including back-to-back) is consumed.
module ps2_key_tracker
    import ps2_kb_pkg::*;
#(
    parameter int                      NUM_KEYS       = 3,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {KC_RIGHT, KC_LEFT, KC_ENTER},
    parameter int                      TIMEOUT_CYCLES = 2_500_000
) (
`ifdef PS2_KEY_REPEAT_EN
    output logic [NUM_KEYS-1:0]        key_repeat,
`endif
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [7:0]                 ps2_key_data,
    input  logic                       ps2_key_pressed,
    output logic [NUM_KEYS-1:0]        key_held,
    output logic [NUM_KEYS-1:0]        key_press,
    output logic [NUM_KEYS-1:0]        key_release,
    output logic [8:0]                 last_code,
    output logic                       code_valid
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                int_rst;

    ps2_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    ps2_code_t           last_code_q, last_code_d;
    logic                code_valid_q, code_valid_d;
`ifdef PS2_KEY_REPEAT_EN
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
`endif

    ps2_code_t           cur_code;
    logic [NUM_KEYS-1:0] match;

    // Reset synchroniser: assertion is immediate, release aligns to the clock.
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= rst_sync_d;
    end
    assign int_rst = rst_sync_q[1];

    // Code that would complete if the current byte is not a prefix.
    assign cur_code = {state_is_ext(state_q), ps2_key_data};

    ps2_code_match #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES)
    ) u_match (
        .code  (cur_code),
        .match (match)
    );

    // Next-state: prefix FSM, prefix timeout and per-key held/pulse updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        held_d       = held_q;
        press_d      = '0;
        release_d    = '0;
        last_code_d  = last_code_q;
        code_valid_d = 1'b0;
`ifdef PS2_KEY_REPEAT_EN
        repeat_d     = '0;
`endif
        if (ps2_key_pressed) begin
            // A strobe always wins over a simultaneous expiry.
            cnt_d = '0;
            if (ps2_key_data == PS2_PFX_EXT) begin
                state_d = EXT;
            end else if (ps2_key_data == PS2_PFX_BRK) begin
                state_d = state_is_ext(state_q) ? EXT_BRK : BRK;
            end else begin
                state_d      = IDLE;
                last_code_d  = cur_code;
                code_valid_d = 1'b1;
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (match[i]) begin
                        if (state_is_brk(state_q)) begin
                            held_d[i]    = 1'b0;
                            release_d[i] = held_q[i];
                        end else if (!held_q[i]) begin
                            held_d[i]  = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
`ifdef PS2_KEY_REPEAT_EN
                            repeat_d[i] = 1'b1;
`endif
                        end
                    end
                end
            end
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_EXPIRE) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and registered outputs; reset drops any prefix and held keys silently.
    always_ff @(posedge CLOCK_50 or posedge int_rst) begin
        if (int_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            held_q       <= '0;
            press_q      <= '0;
            release_q    <= '0;
            last_code_q  <= '0;
            code_valid_q <= 1'b0;
`ifdef PS2_KEY_REPEAT_EN
            repeat_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            held_q       <= held_d;
            press_q      <= press_d;
            release_q    <= release_d;
            last_code_q  <= last_code_d;
            code_valid_q <= code_valid_d;
`ifdef PS2_KEY_REPEAT_EN
            repeat_q     <= repeat_d;
`endif
        end
    end

    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign last_code   = last_code_q;
    assign code_valid  = code_valid_q;
`ifdef PS2_KEY_REPEAT_EN
    assign key_repeat  = repeat_q;
`endif

endmodule
